// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
module execute_cycle (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] PCPlus4_E,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic [2:0]  funct3_E,
  input  logic [3:0]  alu_op_E,
  input  logic        opa_sel_E,
  input  logic        opb_sel_E,
  input  logic        br_E,
  input  logic        jal_E,
  input  logic        jalr_E,
  input  logic        rd_wren_E,
  input  logic        mem_wren_E,
  input  logic        insn_vld_E,
  input  logic [1:0]  wb_sel_E,
  input  logic [1:0]  fwd_a_E,
  input  logic [1:0]  fwd_b_E,
  input  logic [31:0] Result_W,
  output logic [31:0] ALUResult_M,
  output logic [31:0] WriteData_M,
  output logic [31:0] PCPlus4_M,
  output logic [4:0]  RD_M,
  output logic [2:0]  funct3_M,
  output logic [1:0]  wb_sel_M,
  output logic        rd_wren_M,
  output logic        mem_wren_M,
  output logic        insn_vld_M,
  output logic        PCSrc_E,
  output logic [31:0] PCTarget_E,
  output logic [4:0]  RS1_E_out,
  output logic [4:0]  RS2_E_out,
  output logic [4:0]  RD_E_out
);

  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_alu;
  logic        w_cond;
  logic [31:0] w_jalr_sum;

  // Forwarding muxes; ALUResult_M is this stage's own registered result.
  always_comb begin
    w_src_a = RD1_E;
    w_src_b = RD2_E;
    case (fwd_a_E)
      2'b01:   w_src_a = Result_W;
      2'b10:   w_src_a = ALUResult_M;
      default: w_src_a = RD1_E;
    endcase
    case (fwd_b_E)
      2'b01:   w_src_b = Result_W;
      2'b10:   w_src_b = ALUResult_M;
      default: w_src_b = RD2_E;
    endcase
  end

  assign w_op_a = opa_sel_E ? PC_E : w_src_a;
  assign w_op_b = opb_sel_E ? Imm_E : w_src_b;

  // ALU
  always_comb begin
    w_alu = 32'd0;
    case (alu_op_E)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a << w_op_b[4:0];
      4'd3:    w_alu = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
      4'd4:    w_alu = {31'd0, (w_op_a < w_op_b)};
      4'd5:    w_alu = w_op_a ^ w_op_b;
      4'd6:    w_alu = w_op_a >> w_op_b[4:0];
      4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
      4'd8:    w_alu = w_op_a | w_op_b;
      4'd9:    w_alu = w_op_a & w_op_b;
      4'd10:   w_alu = w_op_b;
      default: w_alu = 32'd0;
    endcase
  end

  // Branch compare always uses the forwarded registers, never the immediate.
  always_comb begin
    w_cond = 1'b0;
    case (funct3_E)
      3'b000:  w_cond = (w_src_a == w_src_b);
      3'b001:  w_cond = (w_src_a != w_src_b);
      3'b100:  w_cond = ($signed(w_src_a) < $signed(w_src_b));
      3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_src_b));
      3'b110:  w_cond = (w_src_a < w_src_b);
      3'b111:  w_cond = (w_src_a >= w_src_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_src_a + Imm_E;
  assign PCSrc_E    = insn_vld_E & (jal_E | jalr_E | (br_E & w_cond));
  assign PCTarget_E = jalr_E ? {w_jalr_sum[31:1], 1'b0} : (PC_E + Imm_E);
  assign RS1_E_out  = RS1_E;
  assign RS2_E_out  = RS2_E;
  assign RD_E_out   = RD_E;

  // EX/MEM register; bubbles and x0 destinations never produce writes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ALUResult_M <= 32'd0;
      WriteData_M <= 32'd0;
      PCPlus4_M   <= 32'd0;
      RD_M        <= 5'd0;
      funct3_M    <= 3'd0;
      wb_sel_M    <= 2'd0;
      rd_wren_M   <= 1'b0;
      mem_wren_M  <= 1'b0;
      insn_vld_M  <= 1'b0;
    end else begin
      ALUResult_M <= w_alu;
      WriteData_M <= w_src_b;
      PCPlus4_M   <= PCPlus4_E;
      RD_M        <= RD_E;
      funct3_M    <= funct3_E;
      wb_sel_M    <= wb_sel_E;
      rd_wren_M   <= rd_wren_E & insn_vld_E & (RD_E != 5'd0);
      mem_wren_M  <= mem_wren_E & insn_vld_E;
      insn_vld_M  <= insn_vld_E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized bench for execute_cycle with a behavioural reference model
// and directed cases for reset, ALU corners, forwarding, branches and bubbles.
module tb_execute_cycle;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E, Result_W;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [2:0]  funct3_E;
  logic [3:0]  alu_op_E;
  logic        opa_sel_E, opb_sel_E, br_E, jal_E, jalr_E;
  logic        rd_wren_E, mem_wren_E, insn_vld_E;
  logic [1:0]  wb_sel_E, fwd_a_E, fwd_b_E;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M, PCTarget_E;
  logic [4:0]  RD_M, RS1_E_out, RS2_E_out, RD_E_out;
  logic [2:0]  funct3_M;
  logic [1:0]  wb_sel_M;
  logic        rd_wren_M, mem_wren_M, insn_vld_M, PCSrc_E;

  int checks = 0;
  int failures = 0;

  // Model of the EX/MEM register contents
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_wb;
  logic        m_rdw, m_mw, m_vld;

  execute_cycle dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_E(Imm_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .funct3_E(funct3_E), .alu_op_E(alu_op_E),
    .opa_sel_E(opa_sel_E), .opb_sel_E(opb_sel_E), .br_E(br_E), .jal_E(jal_E), .jalr_E(jalr_E),
    .rd_wren_E(rd_wren_E), .mem_wren_E(mem_wren_E), .insn_vld_E(insn_vld_E),
    .wb_sel_E(wb_sel_E), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .Result_W(Result_W),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .RD_M(RD_M), .funct3_M(funct3_M), .wb_sel_M(wb_sel_M),
    .rd_wren_M(rd_wren_M), .mem_wren_M(mem_wren_M), .insn_vld_M(insn_vld_M),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .RS1_E_out(RS1_E_out), .RS2_E_out(RS2_E_out), .RD_E_out(RD_E_out)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return 32'(int'(a) >>> sh);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rd, input logic [31:0] w, input logic [31:0] m);
    if (f == 2'd1) return w;
    if (f == 2'd2) return m;
    return rd;
  endfunction

  task automatic zero_model();
    m_alu = 32'd0; m_wd = 32'd0; m_pc4 = 32'd0; m_rd = 5'd0; m_f3 = 3'd0;
    m_wb = 2'd0; m_rdw = 1'b0; m_mw = 1'b0; m_vld = 1'b0;
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".alu"}, ALUResult_M, m_alu);
    chk({tag, ".wd"}, WriteData_M, m_wd);
    chk({tag, ".pc4"}, PCPlus4_M, m_pc4);
    chk({tag, ".rd"}, {27'd0, RD_M}, {27'd0, m_rd});
    chk({tag, ".f3"}, {29'd0, funct3_M}, {29'd0, m_f3});
    chk({tag, ".wb"}, {30'd0, wb_sel_M}, {30'd0, m_wb});
    chk({tag, ".ctl"}, {29'd0, rd_wren_M, mem_wren_M, insn_vld_M}, {29'd0, m_rdw, m_mw, m_vld});
  endtask

  // Called at a negedge with inputs driven; checks combinational outputs,
  // clocks once and checks the captured EX/MEM contents.
  task automatic step(input string tag);
    logic [31:0] sa, sb, a, b, tgt;
    logic        cond, taken;
    #1;
    sa = pick(fwd_a_E, RD1_E, Result_W, m_alu);
    sb = pick(fwd_b_E, RD2_E, Result_W, m_alu);
    a  = opa_sel_E ? PC_E : sa;
    b  = opb_sel_E ? Imm_E : sb;
    case (funct3_E)
      3'd0: cond = (sa == sb);
      3'd1: cond = (sa != sb);
      3'd4: cond = (int'(sa) < int'(sb));
      3'd5: cond = (int'(sa) >= int'(sb));
      3'd6: cond = (sa < sb);
      3'd7: cond = (sa >= sb);
      default: cond = 1'b0;
    endcase
    taken = insn_vld_E && (jal_E || jalr_E || (br_E && cond));
    tgt = jalr_E ? ((sa + Imm_E) & 32'hFFFF_FFFE) : (PC_E + Imm_E);
    chk({tag, ".pcsrc"}, {31'd0, PCSrc_E}, {31'd0, taken});
    if (taken) chk({tag, ".tgt"}, PCTarget_E, tgt);
    else chk({tag, ".tgt_any"}, PCTarget_E, tgt);
    chk({tag, ".rsout"}, {17'd0, RS1_E_out, RS2_E_out, RD_E_out}, {17'd0, RS1_E, RS2_E, RD_E});
    @(posedge i_clk);
    m_alu = ref_alu(int'(alu_op_E), a, b);
    m_wd  = sb;
    m_pc4 = PCPlus4_E;
    m_rd  = RD_E;
    m_f3  = funct3_E;
    m_wb  = wb_sel_E;
    m_vld = insn_vld_E;
    m_rdw = insn_vld_E && rd_wren_E && (RD_E != 5'd0);
    m_mw  = insn_vld_E && mem_wren_E;
    #1;
    check_m(tag);
    @(negedge i_clk);
  endtask

  task automatic nop_inputs();
    RD1_E = 32'd0; RD2_E = 32'd0; Imm_E = 32'd0; PC_E = 32'd0; PCPlus4_E = 32'd4;
    Result_W = 32'd0; RS1_E = 5'd1; RS2_E = 5'd2; RD_E = 5'd3; funct3_E = 3'd0;
    alu_op_E = 4'd0; opa_sel_E = 1'b0; opb_sel_E = 1'b0; br_E = 1'b0; jal_E = 1'b0;
    jalr_E = 1'b0; rd_wren_E = 1'b1; mem_wren_E = 1'b0; insn_vld_E = 1'b1;
    wb_sel_E = 2'd0; fwd_a_E = 2'd0; fwd_b_E = 2'd0;
  endtask

  task automatic alu_case(input logic [3:0] op, input logic [31:0] b, input logic [31:0] exp, input string tag);
    nop_inputs();
    RD1_E = 32'h8000_0000; Imm_E = b; opb_sel_E = 1'b1; alu_op_E = op;
    step(tag);
    chk({tag, ".plan"}, ALUResult_M, exp);
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic exp, input string tag);
    nop_inputs();
    PC_E = 32'h100; Imm_E = 32'h20; br_E = 1'b1; funct3_E = f3; rd_wren_E = 1'b0;
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    #1;
    chk({tag, ".plan"}, {31'd0, PCSrc_E}, {31'd0, exp});
    if (exp) chk({tag, ".plan_tgt"}, PCTarget_E, 32'h120);
    else chk({tag, ".plan_nt_tgt"}, PCTarget_E, 32'h120);
    step(tag);
  endtask

  initial begin
    zero_model();
    // Reset with junk inputs
    i_reset = 1'b0;
    nop_inputs();
    RD1_E = 32'hDEAD_BEEF; RD2_E = 32'hCAFE_F00D; RD_E = 5'd7; mem_wren_E = 1'b1;
    PCPlus4_E = 32'h1234_5678; wb_sel_E = 2'd3; funct3_E = 3'd5;
    repeat (2) @(posedge i_clk);
    #1;
    check_m("reset");
    @(negedge i_clk);
    i_reset = 1'b1;
    step("first_capture");
    chk("first_capture.plan_mw", {31'd0, mem_wren_M}, 32'd1);

    alu_case(4'd0, 32'd1, 32'h8000_0001, "add");
    alu_case(4'd1, 32'd1, 32'h7FFF_FFFF, "sub");
    alu_case(4'd7, 32'd4, 32'hF800_0000, "sra");
    alu_case(4'd6, 32'd4, 32'h0800_0000, "srl");
    alu_case(4'd3, 32'd1, 32'd1, "slt");
    alu_case(4'd4, 32'd1, 32'd0, "sltu");
    alu_case(4'd12, 32'd1, 32'd0, "op12");

    // Forwarding from EX/MEM then from writeback
    nop_inputs(); RD1_E = 32'd9; step("fwd_setup");
    nop_inputs(); RD1_E = 32'd5; fwd_a_E = 2'b10; Imm_E = 32'd1; opb_sel_E = 1'b1;
    step("fwd_m");
    chk("fwd_m.plan", ALUResult_M, 32'd10);
    nop_inputs(); RD1_E = 32'd5; fwd_a_E = 2'b01; Result_W = 32'd3; Imm_E = 32'd1; opb_sel_E = 1'b1;
    step("fwd_w");
    chk("fwd_w.plan", ALUResult_M, 32'd4);
    nop_inputs(); RD2_E = 32'd1; fwd_b_E = 2'b10; mem_wren_E = 1'b1; Imm_E = 32'h40; opb_sel_E = 1'b1;
    step("store_fwd");
    chk("store_fwd.plan", WriteData_M, 32'd4);

    branch_case(3'b100, 1'b1, "blt");
    branch_case(3'b110, 1'b0, "bltu");
    branch_case(3'b010, 1'b0, "f3_010");

    // JALR, valid and bubble
    nop_inputs(); jalr_E = 1'b1; RD1_E = 32'h203; Imm_E = 32'h4; #1;
    chk("jalr.plan_tgt", PCTarget_E, 32'h206);
    chk("jalr.plan_src", {31'd0, PCSrc_E}, 32'd1);
    step("jalr");
    nop_inputs(); jalr_E = 1'b1; RD1_E = 32'h203; Imm_E = 32'h4; insn_vld_E = 1'b0; #1;
    chk("jalr_bubble.plan", {31'd0, PCSrc_E}, 32'd0);
    step("jalr_bubble");

    // Bubble and x0
    nop_inputs(); insn_vld_E = 1'b0; mem_wren_E = 1'b1; rd_wren_E = 1'b1;
    step("bubble");
    chk("bubble.plan", {30'd0, mem_wren_M, rd_wren_M}, 32'd0);
    nop_inputs(); RD_E = 5'd0; rd_wren_E = 1'b1;
    step("x0");
    chk("x0.plan", {31'd0, rd_wren_M}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      Imm_E = $urandom; PC_E = $urandom; PCPlus4_E = PC_E + 32'd4; Result_W = $urandom;
      RS1_E = 5'($urandom); RS2_E = 5'($urandom);
      RD_E = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      funct3_E = 3'($urandom); alu_op_E = 4'($urandom);
      opa_sel_E = 1'($urandom); opb_sel_E = 1'($urandom);
      br_E = 1'($urandom); jal_E = ($urandom_range(0, 7) == 0);
      jalr_E = ($urandom_range(0, 7) == 0);
      rd_wren_E = 1'($urandom); mem_wren_E = 1'($urandom);
      insn_vld_E = ($urandom_range(0, 4) != 0);
      wb_sel_E = 2'($urandom); fwd_a_E = 2'($urandom); fwd_b_E = 2'($urandom);
      step("rand");
    end

    // Store in flight, then reset mid-cycle must drop it at once
    nop_inputs(); mem_wren_E = 1'b1; RD2_E = 32'h55AA_55AA;
    step("pre_midreset");
    #2;
    i_reset = 1'b0;
    #1;
    zero_model();
    check_m("midreset");
    @(negedge i_clk);
    i_reset = 1'b1;
    nop_inputs(); RD1_E = 32'h77; Imm_E = 32'h1; opb_sel_E = 1'b1; fwd_a_E = 2'b10;
    step("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
